lock_loss_monitor: RTL and testbench



---
 rtl/lock_loss_monitor.sv | 199 +++++++++++++++++++
 tb/tb_lock_loss_monitor.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_loss_monitor.sv
`default_nettype none
// ============================================================================
// Module   : lock_loss_monitor
// Brief    : Filters clock-source lock/error indicators, requests a restart on
//            loss of lock while running, keeps loss counters and sticky flags.
// Revision : 1.0
// ============================================================================
module lock_loss_monitor #(
  parameter int          FILT_LEN = 8,
  parameter int          REQ_PW   = 4,
  parameter logic [19:0] HOLDOFF  = 20'd40000,
  parameter int          CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             EOS,
  input  logic             RUN,
  input  logic             DAQ_MMCM_LOCK,
  input  logic             TRG_MMCM_LOCK,
  input  logic             QPLL_LOCK,
  input  logic             QPLL_ERROR,
  input  logic             CLR_CNT,
  output logic             RESTART_REQ,
  output logic             LOCK_OK,
  output logic [CNT_W-1:0] LOSS_CNT_DAQ,
  output logic [CNT_W-1:0] LOSS_CNT_TRG,
  output logic [CNT_W-1:0] LOSS_CNT_QPLL,
  output logic [3:0]       LOSS_FLAGS,
  output logic [1:0]       MON_STATE
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FAULT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [7:0]       c_filt_last = 8'(FILT_LEN - 1);
  localparam logic [19:0]      c_pw_last   = 20'(REQ_PW - 1);
  localparam logic [19:0]      c_hold_last = HOLDOFF - 20'd1;
  localparam logic [CNT_W-1:0] c_cnt_max   = '1;
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  logic [3:0]       w_async;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       w_filt;
  logic [3:0]       r_filt_d;
  logic [2:0]       w_loss;
  logic             w_err_ev;
  logic             w_any_ev;
  logic [2:0]       w_inc;
  logic             r_lock_ok;
  logic             r_req;
  logic [3:0]       r_flags;
  logic [19:0]      r_tmr;
  logic             w_tmr_clr;
  logic             w_count_en;
  logic [CNT_W-1:0] w_cnt [3];
  state_t           r_state;
  state_t           w_state_nxt;

  // Bit order: [0] DAQ lock, [1] TRG lock, [2] QPLL lock, [3] QPLL error
  assign w_async = {QPLL_ERROR, QPLL_LOCK, TRG_MMCM_LOCK, DAQ_MMCM_LOCK};

  always_ff @(posedge CLK or negedge EOS) begin
    if (!EOS) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_async;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_filt
      logic       r_val;
      logic [7:0] r_run;

      // The filtered level flips only after FILT_LEN consecutive disagreeing samples.
      always_ff @(posedge CLK or negedge EOS) begin
        if (!EOS) begin
          r_val <= 1'b0;
          r_run <= '0;
        end else if (r_sync2[gi] == r_val) begin
          r_run <= '0;
        end else if (r_run == c_filt_last) begin
          r_val <= ~r_val;
          r_run <= '0;
        end else begin
          r_run <= r_run + 8'd1;
        end
      end

      assign w_filt[gi] = r_val;
    end
  endgenerate

  always_ff @(posedge CLK or negedge EOS) begin
    if (!EOS) begin
      r_filt_d  <= '0;
      r_lock_ok <= 1'b0;
    end else begin
      r_filt_d  <= w_filt;
      r_lock_ok <= &w_filt[2:0] & ~w_filt[3];
    end
  end

  assign w_loss   = r_filt_d[2:0] & ~w_filt[2:0];
  assign w_err_ev = ~r_filt_d[3] & w_filt[3];
  assign w_any_ev = (|w_loss) | w_err_ev;
  assign w_inc    = {w_loss[2] | w_err_ev, w_loss[1:0]};

  always_ff @(posedge CLK or negedge EOS) begin
    if (!EOS) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RUN low in ARMED wins over a same-cycle event; FAULT/HOLD ignore RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_clr   = 1'b1;
    w_count_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (RUN && r_lock_ok) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (!RUN) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_count_en = 1'b1;
          if (w_any_ev) w_state_nxt = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (r_tmr == c_pw_last) w_state_nxt = ST_HOLD;
        else                    w_tmr_clr   = 1'b0;
      end
      ST_HOLD: begin
        if (r_tmr == c_hold_last) w_state_nxt = ST_IDLE;
        else                      w_tmr_clr   = 1'b0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge EOS) begin
    if (!EOS) begin
      r_tmr <= '0;
      r_req <= 1'b0;
    end else begin
      r_tmr <= w_tmr_clr ? 20'd0 : r_tmr + 20'd1;
      r_req <= (w_state_nxt == ST_FAULT);
    end
  end

  generate
    for (genvar gc = 0; gc < 3; gc++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge CLK or negedge EOS) begin
        if (!EOS) begin
          r_cnt <= '0;
        end else if (CLR_CNT) begin
          r_cnt <= '0;
        end else if (w_count_en && w_inc[gc] && (r_cnt != c_cnt_max)) begin
          r_cnt <= r_cnt + c_cnt_one;
        end
      end

      assign w_cnt[gc] = r_cnt;
    end
  endgenerate

  always_ff @(posedge CLK or negedge EOS) begin
    if (!EOS) begin
      r_flags <= '0;
    end else if (CLR_CNT) begin
      r_flags <= '0;
    end else if (w_count_en) begin
      r_flags <= r_flags | {w_err_ev, w_loss};
    end
  end

  assign RESTART_REQ   = r_req;
  assign LOCK_OK       = r_lock_ok;
  assign LOSS_CNT_DAQ  = w_cnt[0];
  assign LOSS_CNT_TRG  = w_cnt[1];
  assign LOSS_CNT_QPLL = w_cnt[2];
  assign LOSS_FLAGS    = r_flags;
  assign MON_STATE     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_lock_loss_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_loss_monitor
// Brief    : Directed scenarios plus randomized lock/error activity checked
//            against a timestamp-based behavioural model.
// Revision : 1.0
// ============================================================================
module tb_lock_loss_monitor;

  localparam int          FL   = 8;
  localparam int          PW   = 4;
  localparam int          HOI  = 40;
  localparam logic [19:0] HO   = 20'd40;
  localparam int          CW   = 8;
  localparam int          CMAX = (1 << CW) - 1;

  logic          CLK;
  logic          EOS;
  logic          RUN;
  logic          DAQ_MMCM_LOCK;
  logic          TRG_MMCM_LOCK;
  logic          QPLL_LOCK;
  logic          QPLL_ERROR;
  logic          CLR_CNT;
  logic          RESTART_REQ;
  logic          LOCK_OK;
  logic [CW-1:0] LOSS_CNT_DAQ;
  logic [CW-1:0] LOSS_CNT_TRG;
  logic [CW-1:0] LOSS_CNT_QPLL;
  logic [3:0]    LOSS_FLAGS;
  logic [1:0]    MON_STATE;

  int errors = 0;
  int checks = 0;

  lock_loss_monitor #(
    .FILT_LEN (FL),
    .REQ_PW   (PW),
    .HOLDOFF  (HO),
    .CNT_W    (CW)
  ) dut (
    .CLK           (CLK),
    .EOS           (EOS),
    .RUN           (RUN),
    .DAQ_MMCM_LOCK (DAQ_MMCM_LOCK),
    .TRG_MMCM_LOCK (TRG_MMCM_LOCK),
    .QPLL_LOCK     (QPLL_LOCK),
    .QPLL_ERROR    (QPLL_ERROR),
    .CLR_CNT       (CLR_CNT),
    .RESTART_REQ   (RESTART_REQ),
    .LOCK_OK       (LOCK_OK),
    .LOSS_CNT_DAQ  (LOSS_CNT_DAQ),
    .LOSS_CNT_TRG  (LOSS_CNT_TRG),
    .LOSS_CNT_QPLL (LOSS_CNT_QPLL),
    .LOSS_FLAGS    (LOSS_FLAGS),
    .MON_STATE     (MON_STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: a filtered level changes once the last FL raw samples, seen two
  // samples late, all disagree with it. FSM phases come from the fault timestamp.
  int       m_q [4][$];
  bit       m_filt [4];
  bit       m_prev [4];
  bit       m_lock_ok;
  bit       m_req;
  int       m_state;
  int       m_fault_cyc;
  int       m_cyc;
  int       m_cnt [3];
  bit [3:0] m_flags;

  always @(posedge CLK or negedge EOS) begin : p_model
    bit ev_loss [3];
    bit ev_err;
    bit ev_any;
    bit flip;
    bit raw [4];
    int nst;
    int ph;
    if (!EOS) begin
      for (int i = 0; i < 4; i++) begin
        m_filt[i] = 1'b0;
        m_prev[i] = 1'b0;
        m_q[i].delete();
        for (int j = 0; j < FL + 2; j++) m_q[i].push_back(0);
      end
      for (int k = 0; k < 3; k++) m_cnt[k] = 0;
      m_lock_ok = 1'b0;
      m_req     = 1'b0;
      m_state   = 0;
      m_flags   = '0;
    end else begin
      m_cyc++;
      for (int k = 0; k < 3; k++) ev_loss[k] = m_prev[k] && !m_filt[k];
      ev_err = !m_prev[3] && m_filt[3];
      ev_any = ev_loss[0] || ev_loss[1] || ev_loss[2] || ev_err;
      nst = m_state;
      case (m_state)
        0: if (RUN && m_lock_ok) nst = 1;
        1: begin
          if (!RUN) begin
            nst = 0;
          end else begin
            if (ev_any) begin
              nst = 2;
              m_fault_cyc = m_cyc;
            end
            for (int k = 0; k < 2; k++)
              if (ev_loss[k]) begin
                if (m_cnt[k] < CMAX) m_cnt[k]++;
                m_flags[k] = 1'b1;
              end
            if (ev_loss[2] || ev_err) begin
              if (m_cnt[2] < CMAX) m_cnt[2]++;
            end
            if (ev_loss[2]) m_flags[2] = 1'b1;
            if (ev_err)     m_flags[3] = 1'b1;
          end
        end
        default: begin
          ph  = m_cyc - m_fault_cyc;
          nst = (ph < PW) ? 2 : (ph < PW + HOI) ? 3 : 0;
        end
      endcase
      if (CLR_CNT) begin
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        m_flags = '0;
      end
      m_state   = nst;
      m_req     = (nst == 2);
      m_lock_ok = m_filt[0] && m_filt[1] && m_filt[2] && !m_filt[3];
      m_prev    = m_filt;
      raw[0] = DAQ_MMCM_LOCK;
      raw[1] = TRG_MMCM_LOCK;
      raw[2] = QPLL_LOCK;
      raw[3] = QPLL_ERROR;
      for (int i = 0; i < 4; i++) begin
        flip = 1'b1;
        for (int j = 1; j <= FL; j++) if (m_q[i][j] == int'(m_filt[i])) flip = 1'b0;
        if (flip) m_filt[i] = !m_filt[i];
        m_q[i].push_front(int'(raw[i]));
        void'(m_q[i].pop_back());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, output bit ok);
    int n;
    n = 0;
    while (MON_STATE !== st && n < budget) begin
      tick(1);
      n++;
    end
    ok = (MON_STATE === st);
  endtask

  task automatic do_reset();
    EOS = 1'b0;
    RUN = 1'b1;
    DAQ_MMCM_LOCK = 1'b1;
    TRG_MMCM_LOCK = 1'b1;
    QPLL_LOCK     = 1'b1;
    QPLL_ERROR    = 1'b0;
    CLR_CNT       = 1'b0;
    tick(2);
    EOS = 1'b1;
  endtask

  task automatic reset_and_arm(input string name);
    bit ok;
    do_reset();
    wait_state(2'd1, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_arm: MON_STATE=%0d required 1 within 40 cycles", name, MON_STATE);
    end
  endtask

  task automatic test_reset();
    EOS = 1'b0;
    RUN = 1'b1;
    DAQ_MMCM_LOCK = 1'b1;
    TRG_MMCM_LOCK = 1'b1;
    QPLL_LOCK     = 1'b1;
    QPLL_ERROR    = 1'b0;
    CLR_CNT       = 1'b0;
    tick(3);
    checks++;
    if ({RESTART_REQ, LOCK_OK, MON_STATE} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: req/lock_ok/state=%b/%b/%0d required 0/0/0", RESTART_REQ, LOCK_OK, MON_STATE);
    end
    checks++;
    if ({LOSS_CNT_DAQ, LOSS_CNT_TRG, LOSS_CNT_QPLL, LOSS_FLAGS} !== '0) begin
      errors++;
      $display("FAIL reset_counts: cnts=%0d/%0d/%0d flags=%b required 0/0/0 0000", LOSS_CNT_DAQ, LOSS_CNT_TRG, LOSS_CNT_QPLL, LOSS_FLAGS);
    end
  endtask

  task automatic test_arm();
    EOS = 1'b1;
    tick(10);
    checks++;
    if (LOCK_OK !== 1'b0) begin
      errors++;
      $display("FAIL arm_lock_ok_early: LOCK_OK=%b at edge 9 required 0", LOCK_OK);
    end
    tick(1);
    checks++;
    if (LOCK_OK !== 1'b1 || MON_STATE !== 2'd0) begin
      errors++;
      $display("FAIL arm_lock_ok: LOCK_OK/state=%b/%0d at edge 10 required 1/0", LOCK_OK, MON_STATE);
    end
    tick(1);
    checks++;
    if (MON_STATE !== 2'd1 || RESTART_REQ !== 1'b0) begin
      errors++;
      $display("FAIL arm_state: state/req=%0d/%b at edge 11 required 1/0", MON_STATE, RESTART_REQ);
    end
  endtask

  task automatic test_glitch();
    bit bad;
    bad = 1'b0;
    DAQ_MMCM_LOCK = 1'b0;
    tick(6);
    DAQ_MMCM_LOCK = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (RESTART_REQ !== 1'b0 || MON_STATE !== 2'd1 || LOCK_OK !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL glitch_quiet: request/state/lock change seen, required none");
    end
    checks++;
    if (LOSS_CNT_DAQ !== '0 || LOSS_FLAGS !== 4'b0000) begin
      errors++;
      $display("FAIL glitch_count: LOSS_CNT_DAQ=%0d flags=%b required 0 0000", LOSS_CNT_DAQ, LOSS_FLAGS);
    end
  endtask

  task automatic test_loss();
    TRG_MMCM_LOCK = 1'b0;
    tick(10);
    checks++;
    if (RESTART_REQ !== 1'b0 || MON_STATE !== 2'd1) begin
      errors++;
      $display("FAIL loss_early: req/state=%b/%0d at edge 9 required 0/1", RESTART_REQ, MON_STATE);
    end
    tick(1);
    checks++;
    if (RESTART_REQ !== 1'b1 || MON_STATE !== 2'd2) begin
      errors++;
      $display("FAIL loss_request: req/state=%b/%0d at edge 10 required 1/2", RESTART_REQ, MON_STATE);
    end
    tick(3);
    checks++;
    if (RESTART_REQ !== 1'b1) begin
      errors++;
      $display("FAIL loss_pulse_hold: req=%b at edge 13 required 1", RESTART_REQ);
    end
    tick(1);
    checks++;
    if (RESTART_REQ !== 1'b0 || MON_STATE !== 2'd3) begin
      errors++;
      $display("FAIL loss_pulse_end: req/state=%b/%0d at edge 14 required 0/3", RESTART_REQ, MON_STATE);
    end
    checks++;
    if (LOSS_CNT_TRG !== 8'd1 || LOSS_FLAGS !== 4'b0010 || LOSS_CNT_DAQ !== '0) begin
      errors++;
      $display("FAIL loss_count: trg=%0d daq=%0d flags=%b required 1 0 0010", LOSS_CNT_TRG, LOSS_CNT_DAQ, LOSS_FLAGS);
    end
    TRG_MMCM_LOCK = 1'b1;
    tick(HOI - 1);
    checks++;
    if (MON_STATE !== 2'd3) begin
      errors++;
      $display("FAIL loss_hold: state=%0d at last HOLD cycle required 3", MON_STATE);
    end
    tick(1);
    checks++;
    if (MON_STATE !== 2'd0) begin
      errors++;
      $display("FAIL loss_idle: state=%0d after HOLD required 0", MON_STATE);
    end
    tick(1);
    checks++;
    if (MON_STATE !== 2'd1) begin
      errors++;
      $display("FAIL loss_rearm: state=%0d at REQ_PW+HOLDOFF+1 required 1", MON_STATE);
    end
  endtask

  task automatic test_simultaneous();
    int n_hi;
    reset_and_arm("simul");
    QPLL_LOCK  = 1'b0;
    QPLL_ERROR = 1'b1;
    tick(10);
    n_hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (RESTART_REQ === 1'b1) n_hi++;
    end
    checks++;
    if (n_hi != PW) begin
      errors++;
      $display("FAIL simul_pulse: request high %0d cycles required %0d", n_hi, PW);
    end
    checks++;
    if (LOSS_CNT_QPLL !== 8'd1 || LOSS_FLAGS !== 4'b1100) begin
      errors++;
      $display("FAIL simul_count: qpll=%0d flags=%b required 1 1100", LOSS_CNT_QPLL, LOSS_FLAGS);
    end
    QPLL_LOCK  = 1'b1;
    QPLL_ERROR = 1'b0;
  endtask

  task automatic test_saturation_clear();
    bit ok1;
    bit ok2;
    bit timed_out;
    timed_out = 1'b0;
    reset_and_arm("sat");
    for (int i = 0; i < 256 && !timed_out; i++) begin
      DAQ_MMCM_LOCK = 1'b0;
      wait_state(2'd2, 20, ok1);
      DAQ_MMCM_LOCK = 1'b1;
      wait_state(2'd1, 80, ok2);
      if (!ok1 || !ok2) timed_out = 1'b1;
      if (i == 254) begin
        checks++;
        if (LOSS_CNT_DAQ !== 8'd255) begin
          errors++;
          $display("FAIL sat_255: LOSS_CNT_DAQ=%0d after 255 losses required 255", LOSS_CNT_DAQ);
        end
      end
    end
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL sat_loop: state=%0d, fault/re-arm not reached within budget", MON_STATE);
    end
    checks++;
    if (LOSS_CNT_DAQ !== 8'd255 || LOSS_FLAGS !== 4'b0001) begin
      errors++;
      $display("FAIL sat_hold: LOSS_CNT_DAQ=%0d flags=%b after 256 losses required 255 0001", LOSS_CNT_DAQ, LOSS_FLAGS);
    end
    DAQ_MMCM_LOCK = 1'b0;
    tick(10);
    CLR_CNT = 1'b1;
    tick(1);
    CLR_CNT = 1'b0;
    checks++;
    if (LOSS_CNT_DAQ !== '0 || LOSS_FLAGS !== 4'b0000 || MON_STATE !== 2'd2) begin
      errors++;
      $display("FAIL sat_clear: cnt=%0d flags=%b state=%0d required 0 0000 2", LOSS_CNT_DAQ, LOSS_FLAGS, MON_STATE);
    end
    DAQ_MMCM_LOCK = 1'b1;
  endtask

  task automatic test_run_drop();
    bit bad;
    bad = 1'b0;
    reset_and_arm("rundrop");
    TRG_MMCM_LOCK = 1'b0;
    tick(10);
    RUN = 1'b0;
    tick(1);
    checks++;
    if (MON_STATE !== 2'd0 || RESTART_REQ !== 1'b0 || LOSS_CNT_TRG !== '0 || LOSS_FLAGS !== 4'b0000) begin
      errors++;
      $display("FAIL run_drop: state=%0d req=%b trg=%0d flags=%b required 0 0 0 0000", MON_STATE, RESTART_REQ, LOSS_CNT_TRG, LOSS_FLAGS);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (RESTART_REQ !== 1'b0 || MON_STATE !== 2'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL run_drop_idle: request or state change seen with RUN=0, required none");
    end
    TRG_MMCM_LOCK = 1'b1;
    RUN = 1'b1;
  endtask

  task automatic test_reset_mid_fault();
    bit ok;
    reset_and_arm("midfault");
    DAQ_MMCM_LOCK = 1'b0;
    wait_state(2'd2, 20, ok);
    tick(1);
    checks++;
    if (!ok || RESTART_REQ !== 1'b1) begin
      errors++;
      $display("FAIL midfault_pulse: state=%0d req=%b required 2 1", MON_STATE, RESTART_REQ);
    end
    #1 EOS = 1'b0;
    #1;
    checks++;
    if (RESTART_REQ !== 1'b0 || MON_STATE !== 2'd0) begin
      errors++;
      $display("FAIL midfault_reset: req=%b state=%0d required 0 0", RESTART_REQ, MON_STATE);
    end
    DAQ_MMCM_LOCK = 1'b1;
  endtask

  task automatic test_random();
    int nprint;
    nprint = 0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      checks++;
      if (RESTART_REQ !== m_req || LOCK_OK !== m_lock_ok || MON_STATE !== 2'(m_state) ||
          LOSS_FLAGS !== m_flags || LOSS_CNT_DAQ !== CW'(m_cnt[0]) ||
          LOSS_CNT_TRG !== CW'(m_cnt[1]) || LOSS_CNT_QPLL !== CW'(m_cnt[2])) begin
        errors++;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL random cyc %0d: req/lok/st/flags/daq/trg/qpll got %b/%b/%0d/%b/%0d/%0d/%0d want %b/%b/%0d/%b/%0d/%0d/%0d",
                   c, RESTART_REQ, LOCK_OK, MON_STATE, LOSS_FLAGS, LOSS_CNT_DAQ, LOSS_CNT_TRG, LOSS_CNT_QPLL,
                   m_req, m_lock_ok, m_state, m_flags, m_cnt[0], m_cnt[1], m_cnt[2]);
        end
      end
      if ($urandom_range(0, 23) == 0) DAQ_MMCM_LOCK = ~DAQ_MMCM_LOCK;
      if ($urandom_range(0, 23) == 0) TRG_MMCM_LOCK = ~TRG_MMCM_LOCK;
      if ($urandom_range(0, 23) == 0) QPLL_LOCK     = ~QPLL_LOCK;
      if ($urandom_range(0, 59) == 0) QPLL_ERROR    = ~QPLL_ERROR;
      if ($urandom_range(0, 299) == 0) RUN          = ~RUN;
      CLR_CNT = ($urandom_range(0, 199) == 0);
    end
    CLR_CNT = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    m_cyc       = 0;
    m_fault_cyc = 0;
    test_reset();
    test_arm();
    test_glitch();
    test_loss();
    test_simultaneous();
    test_saturation_clear();
    test_run_drop();
    test_reset_mid_fault();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
